spu_mamrs: RTL and testbench

- Multiply/reduce sequencer for the SPU modular arithmetic unit.
- It is the responder to the exponentiation controller's start_mulred_aequb and start_mulred_anoteqb pulses.
- It steps the word-serial multiplier through a product pass, a reduction pass and a result write-back, then returns a one-cycle spu_mared_red_done.
- Squaring (A==B) uses a triangular product schedule to save multiplier cycles.

---
 rtl/spu_mamrs_pkg.sv | 15 +
 rtl/spu_mamrs_idxctr.sv | 68 ++++++
 rtl/spu_mamrs.sv | 154 +++++++++++++++
 tb/tb_spu_mamrs.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_mamrs_pkg.sv
// Shared SPU definitions for the multiply/reduce sequencer: state encoding
// and the default operand-length field width.
package spu_mamrs_pkg;

  localparam int MAMRS_LEN_W = 6;

  typedef enum logic [2:0] {
    MAMRS_IDLE = 3'd0,
    MAMRS_MUL  = 3'd1,
    MAMRS_RED  = 3'd2,
    MAMRS_WB   = 3'd3,
    MAMRS_DONE = 3'd4
  } mamrs_state_t;

endpackage

// File: rtl/spu_mamrs_idxctr.sv
// Word index counter pair for the multiply/reduce sequencer.
// step_mul walks the product schedule: rectangular (all i,j) for a general
// multiply, triangular (j >= i) for squaring. step_lin walks i linearly for
// the reduction and write-back passes. Both wrap back to zero after the last
// index so the next pass starts from word 0.
module spu_mamrs_idxctr
  import spu_mamrs_pkg::*;
#(
  parameter int LEN_W = MAMRS_LEN_W
) (
  input  logic             clk,
  input  logic             arst_l,
  input  logic             clr,
  input  logic             step_mul,
  input  logic             step_lin,
  input  logic             sq,
  input  logic [LEN_W-1:0] last_idx,
  output logic [LEN_W-1:0] i,
  output logic [LEN_W-1:0] j,
  output logic             i_last,
  output logic             j_last,
  output logic             pair_last
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [LEN_W-1:0] i_next;
  logic [LEN_W-1:0] j_next;

  assign i_last    = (i == last_idx);
  assign j_last    = (j == last_idx);
  assign pair_last = i_last & j_last;

  // Next index values; clear has priority over any advance.
  always_comb begin
    i_next = i;
    j_next = j;
    if (clr) begin
      i_next = '0;
      j_next = '0;
    end else if (step_mul) begin
      if (!j_last) begin
        j_next = j + ONE;
      end else if (!i_last) begin
        i_next = i + ONE;
        // Squaring only needs the upper triangle, so the row restarts on the diagonal.
        j_next = sq ? (i + ONE) : '0;
      end else begin
        i_next = '0;
        j_next = '0;
      end
    end else if (step_lin) begin
      i_next = i_last ? '0 : (i + ONE);
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      i <= '0;
      j <= '0;
    end else begin
      i <= i_next;
      j <= j_next;
    end
  end

endmodule

// File: rtl/spu_mamrs.sv
// SPU multiply/reduce sequencer. Accepts a squaring or general-multiply start
// from the exponentiation controller, drives the word-serial multiplier through
// the product pass and the reduction pass, writes back the result words and
// returns a one-cycle spu_mared_red_done.
module spu_mamrs
  import spu_mamrs_pkg::*;
#(
  parameter int LEN_W = MAMRS_LEN_W
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             se,
  input  logic             spu_maexp_start_mulred_aequb,
  input  logic             spu_maexp_start_mulred_anoteqb,
  input  logic             spu_mactl_kill_op,
  input  logic [LEN_W-1:0] spu_mactl_len,
  input  logic             spu_mul_ack,
  output logic             spu_mamrs_mul_req,
  output logic [LEN_W-1:0] spu_mamrs_oprnd_i,
  output logic [LEN_W-1:0] spu_mamrs_oprnd_j,
  output logic             spu_mamrs_b_sel,
  output logic             spu_mamrs_red_phase,
  output logic             spu_mamrs_mem_wen,
  output logic [LEN_W-1:0] spu_mamrs_wr_idx,
  output logic             spu_mared_red_done,
  output logic             spu_mamrs_busy
);

  mamrs_state_t     state_reg;
  mamrs_state_t     state_next;
  logic [LEN_W-1:0] len_reg;
  logic             sq_reg;

  logic             kill;
  logic             start_any;
  logic             start_acc;
  logic             step_mul;
  logic             step_lin;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] idx_i;
  logic [LEN_W-1:0] idx_j;
  logic             i_last;
  logic             j_last;
  logic             pair_last;

  // Scan enable only matters once scan chains are stitched in; no functional effect here.
  logic se_unused;
  assign se_unused = se;

  assign kill      = spu_mactl_kill_op;
  assign start_any = spu_maexp_start_mulred_aequb | spu_maexp_start_mulred_anoteqb;
  assign start_acc = (state_reg == MAMRS_IDLE) & start_any & ~kill;
  assign step_mul  = (state_reg == MAMRS_MUL) & spu_mul_ack & ~kill;
  assign step_lin  = (((state_reg == MAMRS_RED) & spu_mul_ack) | (state_reg == MAMRS_WB)) & ~kill;
  // Only used while len_reg != 0; a zero length goes straight to DONE.
  assign last_idx  = len_reg - LEN_W'(1);

  spu_mamrs_idxctr #(
    .LEN_W (LEN_W)
  ) u_idxctr (
    .clk       (rclk),
    .arst_l    (arst_l),
    .clr       (kill | start_acc),
    .step_mul  (step_mul),
    .step_lin  (step_lin),
    .sq        (sq_reg),
    .last_idx  (last_idx),
    .i         (idx_i),
    .j         (idx_j),
    .i_last    (i_last),
    .j_last    (j_last),
    .pair_last (pair_last)
  );

  // State register.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg <= MAMRS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operation parameters captured at start; aequb wins when both starts are seen.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      len_reg <= '0;
      sq_reg  <= 1'b0;
    end else if (kill) begin
      sq_reg  <= 1'b0;
    end else if (start_acc) begin
      len_reg <= spu_mactl_len;
      sq_reg  <= spu_maexp_start_mulred_aequb;
    end
  end

  // Next-state and output decode; kill gates the strobes in its own cycle.
  always_comb begin
    state_next          = state_reg;
    spu_mamrs_mul_req   = 1'b0;
    spu_mamrs_oprnd_i   = '0;
    spu_mamrs_oprnd_j   = '0;
    spu_mamrs_b_sel     = 1'b0;
    spu_mamrs_red_phase = 1'b0;
    spu_mamrs_mem_wen   = 1'b0;
    spu_mamrs_wr_idx    = '0;
    spu_mared_red_done  = 1'b0;
    spu_mamrs_busy      = (state_reg != MAMRS_IDLE);

    case (state_reg)
      MAMRS_IDLE: begin
        if (start_acc) begin
          state_next = (spu_mactl_len == '0) ? MAMRS_DONE : MAMRS_MUL;
        end
      end
      MAMRS_MUL: begin
        spu_mamrs_mul_req = ~kill;
        spu_mamrs_oprnd_i = idx_i;
        spu_mamrs_oprnd_j = idx_j;
        spu_mamrs_b_sel   = ~sq_reg;
        if (spu_mul_ack && pair_last) begin
          state_next = MAMRS_RED;
        end
      end
      MAMRS_RED: begin
        spu_mamrs_mul_req   = ~kill;
        spu_mamrs_red_phase = 1'b1;
        spu_mamrs_oprnd_i   = idx_i;
        if (spu_mul_ack && i_last) begin
          state_next = MAMRS_WB;
        end
      end
      MAMRS_WB: begin
        spu_mamrs_mem_wen = ~kill;
        spu_mamrs_wr_idx  = idx_i;
        if (i_last) begin
          state_next = MAMRS_DONE;
        end
      end
      MAMRS_DONE: begin
        spu_mared_red_done = ~kill;
        state_next         = MAMRS_IDLE;
      end
      default: begin
        state_next = MAMRS_IDLE;
      end
    endcase

    if (kill) begin
      state_next = MAMRS_IDLE;
    end
  end

endmodule

// File: tb/tb_spu_mamrs.sv
// Testbench for spu_mamrs: a work-queue model of the op (product pairs,
// reduction steps, write-back words, done) checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_spu_mamrs;
  import spu_mamrs_pkg::*;

  localparam int LW = MAMRS_LEN_W;
  localparam int K_MUL  = 0;
  localparam int K_RED  = 1;
  localparam int K_WB   = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int i;
    int j;
  } item_t;

  logic          rclk = 1'b0;
  logic          arst_l = 1'b0;
  logic          se = 1'b0;
  logic          aeq = 1'b0;
  logic          aneq = 1'b0;
  logic          kill = 1'b0;
  logic [LW-1:0] len = '0;
  logic          ack = 1'b0;

  logic          mul_req;
  logic [LW-1:0] oprnd_i;
  logic [LW-1:0] oprnd_j;
  logic          b_sel;
  logic          red_phase;
  logic          mem_wen;
  logic [LW-1:0] wr_idx;
  logic          red_done;
  logic          busy;

  spu_mamrs #(.LEN_W(LW)) dut (
    .rclk                           (rclk),
    .arst_l                         (arst_l),
    .se                             (se),
    .spu_maexp_start_mulred_aequb   (aeq),
    .spu_maexp_start_mulred_anoteqb (aneq),
    .spu_mactl_kill_op              (kill),
    .spu_mactl_len                  (len),
    .spu_mul_ack                    (ack),
    .spu_mamrs_mul_req              (mul_req),
    .spu_mamrs_oprnd_i              (oprnd_i),
    .spu_mamrs_oprnd_j              (oprnd_j),
    .spu_mamrs_b_sel                (b_sel),
    .spu_mamrs_red_phase            (red_phase),
    .spu_mamrs_mem_wen              (mem_wen),
    .spu_mamrs_wr_idx               (wr_idx),
    .spu_mared_red_done             (red_done),
    .spu_mamrs_busy                 (busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // observation log for directed checks
  int n_busy, n_req, n_mul, n_red, n_wen, n_done, done_at;
  int bsel_seen;
  int pairs[$];

  // model state
  item_t q[$];
  bit    m_sq;

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic build(bit sq, int l);
    item_t it;
    q.delete();
    m_sq = sq;
    for (int a = 0; a < l; a++) begin
      for (int b = (sq ? a : 0); b < l; b++) begin
        it.kind = K_MUL; it.i = a; it.j = b; q.push_back(it);
      end
    end
    for (int a = 0; a < l; a++) begin
      it.kind = K_RED; it.i = a; it.j = 0; q.push_back(it);
    end
    for (int a = 0; a < l; a++) begin
      it.kind = K_WB; it.i = a; it.j = 0; q.push_back(it);
    end
    it.kind = K_DONE; it.i = 0; it.j = 0; q.push_back(it);
  endtask

  // Per-cycle compare against the work-queue model, then advance the model.
  always @(negedge rclk) begin
    int e_req, e_i, e_j, e_b, e_rp, e_wen, e_wi, e_done, e_busy;
    e_req = 0; e_i = 0; e_j = 0; e_b = 0; e_rp = 0;
    e_wen = 0; e_wi = 0; e_done = 0; e_busy = 0;
    if (!arst_l) begin
      q.delete();
    end else if (q.size() > 0) begin
      e_busy = 1;
      case (q[0].kind)
        K_MUL:  begin e_req = 1; e_i = q[0].i; e_j = q[0].j; e_b = m_sq ? 0 : 1; end
        K_RED:  begin e_req = 1; e_rp = 1; e_i = q[0].i; end
        K_WB:   begin e_wen = 1; e_wi = q[0].i; end
        default: e_done = 1;
      endcase
      if (kill) begin
        e_req = 0; e_wen = 0; e_done = 0;
      end
    end
    chk("mul_req",   mul_req,   e_req);
    chk("oprnd_i",   oprnd_i,   e_i);
    chk("oprnd_j",   oprnd_j,   e_j);
    chk("b_sel",     b_sel,     e_b);
    chk("red_phase", red_phase, e_rp);
    chk("mem_wen",   mem_wen,   e_wen);
    chk("wr_idx",    wr_idx,    e_wi);
    chk("red_done",  red_done,  e_done);
    chk("busy",      busy,      e_busy);
    if (arst_l) begin
      if (kill) begin
        q.delete();
        m_sq = 0;
      end else if (q.size() > 0) begin
        if ((q[0].kind == K_MUL || q[0].kind == K_RED) ? ack : 1'b1) void'(q.pop_front());
      end else if (aeq || aneq) begin
        build(aeq, int'(len));
      end
    end
  end

  // Observation log of DUT activity.
  always @(negedge rclk) begin
    if (arst_l) begin
      if (busy) n_busy++;
      if (mul_req) n_req++;
      if (mul_req && ack && !red_phase) begin
        n_mul++;
        pairs.push_back(int'(oprnd_i) * 100 + int'(oprnd_j));
        bsel_seen = b_sel;
      end
      if (mul_req && ack && red_phase) n_red++;
      if (mem_wen) n_wen++;
      if (red_done) begin
        n_done++;
        done_at = cyc - start_cyc;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic clear_log();
    n_busy = 0; n_req = 0; n_mul = 0; n_red = 0; n_wen = 0; n_done = 0;
    done_at = -1; bsel_seen = -1;
    pairs.delete();
  endtask

  task automatic start_op(bit sq, bit gen, int l);
    clear_log();
    aeq = sq; aneq = gen; len = LW'(l);
    start_cyc = cyc;
    tick();
    aeq = 0; aneq = 0;
  endtask

  function automatic int pair_at(int k);
    return (k < pairs.size()) ? pairs[k] : -1;
  endfunction

  initial begin
    int e1[4];
    int e2[3];
    e1 = '{0, 1, 100, 101};
    e2 = '{0, 1, 101};
    clear_log();

    // reset state
    #2;
    chk("rst_mul_req", mul_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_red_done", red_done, 0);
    chk("rst_mem_wen", mem_wen, 0);
    tick(); tick();
    arst_l = 1;
    tick();

    // general multiply, len=2, ack high
    ack = 1;
    start_op(0, 1, 2);
    repeat (11) tick();
    chk("t1_n_mul", n_mul, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_pair%0d", k), pair_at(k), e1[k]);
    chk("t1_n_red", n_red, 2);
    chk("t1_n_wen", n_wen, 2);
    chk("t1_n_done", n_done, 1);
    chk("t1_done_at", done_at, 9);
    chk("t1_bsel", bsel_seen, 1);

    // squaring, len=2, ack high
    start_op(1, 0, 2);
    repeat (11) tick();
    chk("t2_n_mul", n_mul, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("t2_pair%0d", k), pair_at(k), e2[k]);
    chk("t2_done_at", done_at, 8);
    chk("t2_bsel", bsel_seen, 0);

    // general multiply, len=3, ack every 3rd cycle
    ack = 0;
    start_op(0, 1, 3);
    for (int k = 0; k < 120; k++) begin
      ack = ((k % 3) == 2);
      tick();
    end
    ack = 0;
    chk("t3_n_mul", n_mul, 9);
    chk("t3_n_red", n_red, 3);
    chk("t3_n_wen", n_wen, 3);
    chk("t3_n_done", n_done, 1);

    // zero length
    ack = 1;
    start_op(0, 1, 0);
    repeat (4) tick();
    chk("t4_n_req", n_req, 0);
    chk("t4_n_wen", n_wen, 0);
    chk("t4_done_at", done_at, 1);
    chk("t4_n_busy", n_busy, 1);

    // kill in MUL after two acks
    start_op(0, 1, 2);
    tick(); tick();
    kill = 1;
    #1;
    chk("t5_kill_req", mul_req, 0);
    tick();
    kill = 0;
    chk("t5_idle", busy, 0);
    repeat (10) tick();
    chk("t5_n_mul", n_mul, 2);
    chk("t5_n_done", n_done, 0);

    // restart proceeds from (0,0), then kill in DONE
    start_op(0, 1, 1);
    repeat (3) tick();
    chk("t5b_pair0", pair_at(0), 0);
    chk("t5b_n_mul", n_mul, 1);
    kill = 1;
    #1;
    chk("t5b_kill_done", red_done, 0);
    tick();
    kill = 0;
    chk("t5b_idle", busy, 0);
    repeat (3) tick();
    chk("t5b_n_done", n_done, 0);

    // start coinciding with kill is dropped
    aneq = 1; kill = 1; len = LW'(2);
    tick();
    aneq = 0; kill = 0;
    chk("t5c_dropped", busy, 0);

    // both starts, busy-time start ignored, async reset mid-WB
    ack = 0;
    start_op(1, 1, 1);
    chk("t6_bsel", b_sel, 0);
    tick();
    aneq = 1; len = LW'(3);
    tick();
    aneq = 0;
    ack = 1;
    tick(); tick();
    chk("t6_wen", mem_wen, 1);
    chk("t6_n_mul", n_mul, 1);
    arst_l = 0;
    #1;
    chk("t6_rst_wen", mem_wen, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_req", mul_req, 0);
    tick();
    arst_l = 1;
    repeat (4) tick();
    chk("t6_n_done", n_done, 0);
    chk("t6_busy", busy, 0);

    // back-to-back ops
    start_op(0, 1, 1);
    repeat (3) tick();
    chk("t7_done", red_done, 1);
    tick();
    chk("t7_idle", busy, 0);
    start_op(1, 0, 1);
    repeat (6) tick();
    chk("t7_n_done", n_done, 1);
    chk("t7_done_at", done_at, 4);
    chk("t7_bsel", bsel_seen, 0);

    ack = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
